// File: rtl/simple_adder_pkg.sv
`timescale 1ns/1ps
// simple_adder_pkg: shared widths and types for the registered adder.
// sum_width() gives the carry-extended result width.
package simple_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [DEFAULT_WIDTH-1:0] opnd_t;
  typedef logic [DEFAULT_WIDTH:0]   res_t;

  function automatic int sum_width(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/simple_adder_fa.sv
`timescale 1ns/1ps
// simple_adder_fa: one-bit full adder cell.
// Kept as its own module so the netlist shows per-bit structure.
module simple_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/simple_adder.sv
`timescale 1ns/1ps
// simple_adder: registered unsigned ripple-carry adder, out = {carry, sum}.
// Define SIMPLE_ADDER_INREG_EN to also register in1/in2 (latency 2).
module simple_adder
  import simple_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            in1,
  input  logic [WIDTH-1:0]            in2,
  output logic [sum_width(WIDTH)-1:0] out
);

  localparam int SW = sum_width(WIDTH);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

`ifdef SIMPLE_ADDER_INREG_EN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // Operand stage: capture both operands ahead of the carry chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= in1;
      b_q <= in2;
    end
  end

  assign a = a_q;
  assign b = b_q;
`else
  assign a = in1;
  assign b = in2;
`endif

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [SW-1:0]    out_d;
  logic [SW-1:0]    out_q;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    simple_adder_fa u_fa (
      .a_i   (a[i]),
      .b_i   (b[i]),
      .cin_i (c[i]),
      .s_o   (s[i]),
      .cout_o(c[i+1])
    );
  end

  assign out_d = {c[WIDTH], s};

  // Result stage: sample the chain every edge, cleared at once by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_simple_adder.sv
`timescale 1ns/1ps
// tb_simple_adder: randomized and directed checks of simple_adder.
// Expected sums are queued at drive time and popped by a monitor.
module tb_simple_adder;
  import simple_adder_pkg::*;

`ifdef SIMPLE_ADDER_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
    int         due;
  } item_t;

  logic       clk;
  logic       rst;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [8:0] out;
  bit         clk_en;

  int    cyc;
  int    n_vec;
  int    n_err;
  item_t q[$];

  simple_adder #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .in1(in1),
    .in2(in2),
    .out(out)
  );

  initial clk = 1'bx;
  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string nm, input logic [8:0] act,
                     input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref_sum(input logic [7:0] a,
                                         input logic [7:0] b);
    int s;
    s = int'(a) + int'(b);
    return s[8:0];
  endfunction

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    item_t it;
    it.a   = a;
    it.b   = b;
    it.exp = ref_sum(a, b);
    it.due = cyc + LAT;
    q.push_back(it);
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in1 = a;
    in2 = b;
    push(a, b);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d left want 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: after each edge, compare the entry that is due now.
  always @(posedge clk) begin
    item_t it;
    cyc++;
    #1;
    if (!rst && q.size() != 0 && q[0].due == cyc) begin
      it = q.pop_front();
      chk($sformatf("sum_%h_%h", it.a, it.b), out, it.exp);
    end
  end

  initial begin
    cyc    = 0;
    n_vec  = 0;
    n_err  = 0;
    clk_en = 0;
    rst    = 1'b1;
    in1    = 'x;
    in2    = 'x;

    for (int i = 0; i < 6; i++) begin
      #5us;
      chk("reset_clkx", out, 9'h000);
    end

    in1    = 8'h3C;
    in2    = 8'h11;
    clk    = 1'b0;
    clk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_clk_run", out, 9'h000);
    @(negedge clk);
    rst = 1'b0;
    push(8'h3C, 8'h11);
    drain();

    drive(8'hA5, 8'h0F);
    drive(8'h6F, 8'hC5);
    drive(8'hAF, 8'hCF);
    drive(8'hFF, 8'hFF);
    drive(8'h00, 8'h00);
    drain();

    for (int i = 0; i < 200; i++) begin
      drive(8'($urandom), 8'($urandom));
    end
    drain();

    drive(8'hFF, 8'h01);
    drain();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_now", out, 9'h000);
    @(posedge clk);
    #1;
    chk("rst_hold_edge", out, 9'h000);
    @(negedge clk);
    rst = 1'b0;
    push(8'hFF, 8'h01);
    drain();

    drive(8'h80, 8'h80);
    @(posedge clk);
    rst = 1'b1;
    q.delete();
    #1;
    chk("rst_at_edge", out, 9'h000);
    @(negedge clk);
    rst = 1'b0;
    push(8'h80, 8'h80);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/simple_adder.md
Name: simple_adder

Overview:
- Registered unsigned adder: sums two WIDTH-bit operands, presents the (WIDTH+1)-bit result with carry-out on a registered output.
- Leaf datapath block used as a basic arithmetic element and simulation/netlist reference in the design.
- Built from an explicit ripple-carry chain of full-adder cells so the generated netlist shows per-bit structure.

Parameters:
- WIDTH, 8, operand width in bits; output is WIDTH+1 bits; legal range 1..64.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset; clears all registers immediately, independent of clk
- in1  input  WIDTH  operand A, unsigned
- in2  input  WIDTH  operand B, unsigned
- out  output  WIDTH+1  registered sum in1+in2; MSB is carry-out

Behaviour:
- Arithmetic: unsigned, zero-extended; out = {carry, sum}; never wraps, since WIDTH+1 bits hold max (2^WIDTH-1)*2.
- Combinational core: WIDTH full-adder cells in ripple order; bit 0 carry-in tied to 0; carry-out of cell i feeds cell i+1; carry-out of last cell becomes out[WIDTH].
- Output register: out captured on every rising clk edge; latency 1 cycle from operand change to visible out (feature off).
- No enable or handshake: the register samples every cycle.
- Reset: rst=1 forces out (and any internal register) to all-zero asynchronously; held at 0 while rst=1 regardless of clk activity, including clk=X.
- Release: first rising edge with rst=0 samples the current operands.
- Reset mid-operation: in-flight result discarded; out=0 until the first edge after release.
- X operands: X propagates to out at the next edge (no masking); out remains 0 during reset even with X operands.
- Simultaneous rst assertion and clk edge: reset wins; out=0.

Optional Feature:
- Macro SIMPLE_ADDER_INREG_EN.
- Defined: in1/in2 additionally registered (async reset to 0) before the adder chain; total latency 2 cycles; reset clears both stages.
- Undefined: operands feed the adder chain directly; latency 1 cycle.
- Port list and arithmetic identical in both builds.

Decomposition:
- Package simple_adder_pkg:
  - localparam DEFAULT_WIDTH=8
  - function sum_width(w) returning w+1
  - typedef for the default-width operand
  - typedef for the default-width result
- One sub-module simple_adder_fa: 1-bit full adder (a, b, cin -> s, cout); simple_adder instantiates WIDTH copies in a generate loop.

Test Plan:
- Reset: rst=1 with clk=X and operands X for 30 us -> out=9'h000 throughout. Release rst, clock running -> first captured value follows the operands.
- Basic sum: in1=8'hA5, in2=8'h0F -> out=9'h0B4 one edge later (two edges with SIMPLE_ADDER_INREG_EN).
- Carry-out: in1=8'h6F, in2=8'hC5 -> out=9'h134.
- Large carry: in1=8'hAF, in2=8'hCF -> out=9'h17E.
- Max boundary: in1=in2=8'hFF -> out=9'h1FE.
- Zero boundary: in1=in2=8'h00 -> out=9'h000.
- Async reset mid-stream: operands 8'hFF/8'h01 (out=9'h100), then pulse rst between clock edges -> out=0 immediately without waiting for an edge. After release, the next edge restores 9'h100.
